srl_chain_checker: RTL and testbench

- Downstream self-check stage for a cascaded SRLC32E chain: N_FULL full-length 32-tap SRLs plus a final addressable SRL.
- Taps the same CE, D and A that drive the chain, keeps a bit-accurate reference shift model, and compares the chain's addressed output Q against it every cycle.
- Reports sticky error, error count and compare count so fabric minitests self-check on hardware without a logic analyser.

---
 rtl/srl_chk_pkg.sv | 14 +
 rtl/srl_ref_model.sv | 43 ++++
 rtl/srl_chain_checker.sv | 116 +++++++++++
 tb/tb_srl_chain_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/srl_chk_pkg.sv
// Shared types and helpers for the SRL chain self-check stage.
package srl_chk_pkg;

  localparam int SRL_LEN_DEFAULT = 32;
  localparam int A_W_DEFAULT     = $clog2(SRL_LEN_DEFAULT);

  typedef enum logic {FILL, CHECK} state_t;

  // Total bits held by the chain: N_FULL full SRLs plus the addressed one.
  function automatic int model_len(input int srl_len, input int n_full);
    return srl_len * (n_full + 1);
  endfunction

endpackage

// File: rtl/srl_ref_model.sv
// Bit-accurate reference of the cascaded SRL chain: shift register, fill
// counter and the addressed tap of the last SRL.
module srl_ref_model
  import srl_chk_pkg::*;
#(
  parameter int SRL_LEN = SRL_LEN_DEFAULT,
  parameter int N_FULL  = 2
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              ce,
  input  logic                                              d,
  input  logic [$clog2(SRL_LEN)-1:0]                        a,
  output logic                                              exp_bit,
  output logic                                              vld,
  output logic [$clog2(model_len(SRL_LEN, N_FULL)+1)-1:0]   fill
);

  localparam int M      = model_len(SRL_LEN, N_FULL);
  localparam int BASE   = N_FULL * SRL_LEN;
  localparam int FILL_W = $clog2(M + 1);

  logic [M-1:0]       m;
  logic [SRL_LEN-1:0] last_srl;

  // NOTE: the model storage is reset (the real chain is not); the fill
  // counter then keeps stale chain bits out of every compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      fill <= '0;
    end else if (ce) begin
      m <= {m[M-2:0], d};
      if (fill != FILL_W'(M)) fill <= fill + FILL_W'(1);
    end
  end

  assign last_srl = m[BASE +: SRL_LEN];
  assign exp_bit  = last_srl[a];
  // A tap is trustworthy only once the bit it addresses has really been shifted in.
  assign vld      = int'(fill) > (BASE + int'(a));

endmodule

// File: rtl/srl_chain_checker.sv
// Self-check stage for a cascaded SRLC32E chain: compare pipeline, counters, FSM.
// Optional first-failure capture (FAIL_A, FAIL_FILL) under `SRL_CHK_FIRST_FAIL_EN.
module srl_chain_checker
  import srl_chk_pkg::*;
#(
  parameter int SRL_LEN = SRL_LEN_DEFAULT,
  parameter int N_FULL  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CLR,
  input  logic                        CE,
  input  logic                        D,
  input  logic [$clog2(SRL_LEN)-1:0]  A,
  input  logic                        Q,
  output logic                        ARMED,
  output logic                        ERR,
  output logic [CNT_W-1:0]            ERR_CNT,
  output logic [CNT_W-1:0]            CHK_CNT
`ifdef SRL_CHK_FIRST_FAIL_EN
  ,
  output logic [$clog2(SRL_LEN)-1:0]                       FAIL_A,
  output logic [$clog2(model_len(SRL_LEN, N_FULL)+1)-1:0]  FAIL_FILL
`endif
);

  localparam int M      = model_len(SRL_LEN, N_FULL);
  localparam int FILL_W = $clog2(M + 1);

  logic              exp_bit;
  logic              vld;
  logic [FILL_W-1:0] fill;
  logic              mm_d;
  logic              mm_q;
  logic              vld_q;
  logic              full_next;
  state_t            state;

  srl_ref_model #(
    .SRL_LEN (SRL_LEN),
    .N_FULL  (N_FULL)
  ) u_model (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ce      (CE),
    .d       (D),
    .a       (A),
    .exp_bit (exp_bit),
    .vld     (vld),
    .fill    (fill)
  );

  // A mismatch seen in a CLR cycle is dropped before it enters the pipeline.
  assign mm_d      = vld & (Q ^ exp_bit) & ~CLR;
  assign full_next = (fill == FILL_W'(M)) || (CE && (fill == FILL_W'(M - 1)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mm_q    <= 1'b0;
      vld_q   <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
      CHK_CNT <= '0;
    end else begin
      mm_q  <= mm_d;
      vld_q <= vld;
      if (CLR) begin
        ERR     <= 1'b0;
        ERR_CNT <= '0;
        CHK_CNT <= '0;
      end else begin
        if (mm_q) ERR <= 1'b1;
        if (mm_q && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + CNT_W'(1);
        if (vld_q && (CHK_CNT != '1)) CHK_CNT <= CHK_CNT + CNT_W'(1);
      end
    end
  end

  // ARMED rises on the same edge that completes the fill.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= FILL;
      ARMED <= 1'b0;
    end else begin
      case (state)
        FILL: if (full_next) begin
          state <= CHECK;
          ARMED <= 1'b1;
        end
        CHECK: ARMED <= 1'b1;
        default: begin
          state <= FILL;
          ARMED <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRL_CHK_FIRST_FAIL_EN
  // Capture only the first mismatch: neither flagged in ERR nor still in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FAIL_A    <= '0;
      FAIL_FILL <= '0;
    end else if (CLR) begin
      FAIL_A    <= '0;
      FAIL_FILL <= '0;
    end else if (mm_d && !ERR && !mm_q) begin
      FAIL_A    <= A;
      FAIL_FILL <= fill;
    end
  end
`endif

endmodule

// File: tb/tb_srl_chain_checker.sv
// Randomised scoreboard bench for srl_chain_checker against an ideal chain and
// a queue-based reference of the chain contents.
module tb_srl_chain_checker;

  localparam int SRL_LEN = 32;
  localparam int N_FULL  = 2;
  localparam int CNT_W   = 16;
  localparam int A_W     = 5;
  localparam int M       = SRL_LEN * (N_FULL + 1);
  localparam int BASE    = N_FULL * SRL_LEN;

  logic           CLK;
  logic           RST_N;
  logic           CLR, CE, D, Q;
  logic [A_W-1:0] A;
  logic           ARMED, ERR;
  logic [CNT_W-1:0] ERR_CNT, CHK_CNT;
`ifdef SRL_CHK_FIRST_FAIL_EN
  logic [A_W-1:0] FAIL_A;
  logic [6:0]     FAIL_FILL;
`endif

  srl_chain_checker #(.SRL_LEN(SRL_LEN), .N_FULL(N_FULL), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .CE(CE), .D(D), .A(A), .Q(Q),
    .ARMED(ARMED), .ERR(ERR), .ERR_CNT(ERR_CNT), .CHK_CNT(CHK_CNT)
`ifdef SRL_CHK_FIRST_FAIL_EN
    , .FAIL_A(FAIL_A), .FAIL_FILL(FAIL_FILL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit armed;
    bit err;
    int err_cnt;
    int chk_cnt;
    int fail_a;
    int fail_fill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Ideal chain (never reset) and the reference history (newest first).
  bit chain[$];
  bit hist[$];
  bit pend_mm, pend_vld, m_err, m_armed, first_seen;
  int m_errc, m_chk, m_fa, m_ff;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    pend_mm = 0; pend_vld = 0; m_err = 0; m_armed = 0; first_seen = 0;
    m_errc = 0; m_chk = 0; m_fa = 0; m_ff = 0;
  endtask

  // One clock of stimulus; the reference outcome of that edge goes to the scoreboard.
  task automatic step(input bit ce, input bit d, input logic [A_W-1:0] a,
                      input bit clr, input bit inj);
    int   tap;
    bit   q, vld, expb, mm;
    exp_t e;
    tap = BASE + int'(a);
    q   = chain[tap] ^ inj;
    CE = ce; D = d; A = a; CLR = clr; Q = q;
    @(posedge CLK);
    vld  = hist.size() > tap;
    expb = vld ? hist[tap] : 1'b0;
    mm   = vld && (q != expb) && !clr;
    if (clr) begin
      m_chk = 0; m_errc = 0; m_err = 0; m_fa = 0; m_ff = 0; first_seen = 0;
    end else begin
      m_chk  += int'(pend_vld);
      m_errc += int'(pend_mm);
      if (pend_mm) m_err = 1;
    end
    if (mm && !first_seen) begin
      first_seen = 1;
      m_fa = int'(a);
      m_ff = hist.size();
    end
    pend_mm  = mm;
    pend_vld = vld;
    if (ce) begin
      hist.push_front(d);
      if (hist.size() > M) void'(hist.pop_back());
      chain.push_front(d);
      void'(chain.pop_back());
    end
    if (hist.size() == M) m_armed = 1;
    e.armed = m_armed; e.err = m_err; e.err_cnt = m_errc; e.chk_cnt = m_chk;
    e.fail_a = m_fa; e.fail_fill = m_ff;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_armed"}, ARMED, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_err_cnt"}, ERR_CNT, 0);
    check({tag, "_chk_cnt"}, CHK_CNT, 0);
`ifdef SRL_CHK_FIRST_FAIL_EN
    check({tag, "_fail_a"}, FAIL_A, 0);
    check({tag, "_fail_fill"}, FAIL_FILL, 0);
`endif
  endtask

  // Asynchronous reset placed between edges, after the monitor has drained.
  task automatic async_reset(input string tag);
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  // Monitor: every edge produces one expected record, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("armed", ARMED, e.armed);
        check("err", ERR, e.err);
        check("err_cnt", ERR_CNT, e.err_cnt);
        check("chk_cnt", CHK_CNT, e.chk_cnt);
`ifdef SRL_CHK_FIRST_FAIL_EN
        check("fail_a", FAIL_A, e.fail_a);
        check("fail_fill", FAIL_FILL, e.fail_fill);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lfsr;
    int c0;
    RST_N = 1'b0; CLR = 0; CE = 0; D = 0; A = '0; Q = 0;
    for (int i = 0; i < M; i++) chain.push_back(1'($urandom_range(0, 1)));
    model_reset();
    #2 check_zero("reset");
    #10 RST_N = 1'b1;

    // Single 1 followed by zeros at A=0.
    for (int i = 0; i < 100; i++) begin
      step(1, i == 0, '0, 0, 0);
      if (i == 65) check("first_vld_chk0", CHK_CNT, 0);
      if (i == 66) check("first_vld_chk1", CHK_CNT, 1);
      if (i == 94) check("armed_95_edges", ARMED, 0);
      if (i == 95) check("armed_96_edges", ARMED, 1);
    end

    // LFSR data, address swept every 4 cycles, ideal chain.
    async_reset("rst_p2");
    lfsr = 16'hACE1;
    for (int i = 0; i < 500; i++) begin
      step(1, lfsr[0], A_W'(i / 4), 0, 0);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    check("p2_err", ERR, 0);
    check("p2_err_cnt", ERR_CNT, 0);

    // Same sweep with a single inverted Q at cycle 200.
    async_reset("rst_p3");
    for (int i = 0; i < 240; i++) begin
      step(1, lfsr[0], A_W'(i / 4), 0, i == 200);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (i == 200) check("inj_err_1edge", ERR, 0);
      if (i == 201) begin
        check("inj_err_2edge", ERR, 1);
        check("inj_err_cnt", ERR_CNT, 1);
      end
    end
`ifdef SRL_CHK_FIRST_FAIL_EN
    check("inj_fail_a", FAIL_A, 18);
    check("inj_fail_fill", FAIL_FILL, 96);
`endif

    // CE low for 20 cycles with a static address.
    step(1, 1'($urandom_range(0, 1)), A_W'(7), 0, 0);
    c0 = int'(CHK_CNT);
    for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)), A_W'(7), 0, 0);
    check("ce_hold_chk_delta", int'(CHK_CNT) - c0, 20);

    // CLR together with an injected mismatch.
    step(1, 1'($urandom_range(0, 1)), A_W'(3), 1, 1);
    check("clr_err", ERR, 0);
    check("clr_err_cnt", ERR_CNT, 0);
    check("clr_armed", ARMED, 1);
    for (int i = 0; i < 3; i++) step(1, 1'($urandom_range(0, 1)), A_W'(3), 0, 0);
    check("clr_dropped_err", ERR, 0);

    // Async reset mid-CHECK, then refill against a stale chain.
    for (int i = 0; i < 30; i++)
      step(1, 1'($urandom_range(0, 1)), A_W'($urandom_range(0, 31)), 0, 0);
    async_reset("rst_mid");
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
           A_W'($urandom_range(0, 31)), 0, 0);
    check("refill_no_false_err", ERR, 0);

    // Random mix of injections and clears.
    for (int i = 0; i < 250; i++)
      step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
           A_W'($urandom_range(0, 31)), $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
